// File: rtl/data_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// data_fetch_ctrl
//
// Sequencer for the data-fetch/store unit. One command is taken at a time over a
// CMD_VALID/CMD_READY handshake. Its fields are latched and presented to the fetch
// unit. The controller then steps the fetch unit's word counter through a load
// (BRAM -> PE) or a store (PE -> BRAM). For loads it produces per-word PE load
// strobes that line up with the BRAM read data. Every transfer is guarded by a
// cycle timeout that aborts the operation.
//
// Parameters
//   RD_LAT   BRAM read latency in cycles, addrb -> doutb valid (>= 1)
//   TIMEOUT  max cycles spent in LOAD/STORE before abort (>= 17)
//
// Ports
//   CLK, RSTN                  clock (rising edge), asynchronous active-low reset
//   CMD_VALID / CMD_READY      command handshake; READY is high only when idle
//   CMD_STORE                  0 = load (BRAM->PE), 1 = store (PE->BRAM)
//   CMD_DIMEN                  load length code: N = 2,4,8,16 words
//   CMD_BASE                   BRAM base address
//   CMD_PE_SEL, CMD_PE_SUB     PE routing mode and {PE_SEL_4, PE_SEL_2x2}
//   DIMEN, ADDRESS, PE_SEL,
//   PE_SEL_4, PE_SEL_2x2       latched command fields; they hold until the next accept
//   ADDR_RST                   clears the fetch-unit word counter
//   ADDR_START                 advances the fetch-unit word counter
//   WRADDR_START               enables the BRAM write of the selected PE output
//   FETCH_DONE, STORE_DONE     fetch-unit counter reached N-1 / 3
//   PE_LD, PE_LD_IDX           PE data valid this cycle, word index k of that data
//   BUSY                       controller not idle
//   DONE, ERR                  one-cycle pulses: transfer complete / timeout abort
// -----------------------------------------------------------------------------
module data_fetch_ctrl #(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 32
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_STORE,
  input  logic [1:0] CMD_DIMEN,
  input  logic [3:0] CMD_BASE,
  input  logic [1:0] CMD_PE_SEL,
  input  logic [1:0] CMD_PE_SUB,
  output logic [1:0] DIMEN,
  output logic [3:0] ADDRESS,
  output logic [1:0] PE_SEL,
  output logic       PE_SEL_4,
  output logic       PE_SEL_2x2,
  output logic       ADDR_RST,
  output logic       ADDR_START,
  output logic       WRADDR_START,
  input  logic       FETCH_DONE,
  input  logic       STORE_DONE,
  output logic       PE_LD,
  output logic [3:0] PE_LD_IDX,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_STORE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5,
    S_ABORT = 3'd6
  } state_t;

  // Last count value allowed in LOAD/STORE, and last DRAIN count value.
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(RD_LAT - 1);

  state_t     state_q, state_d;
  logic [7:0] cyc_q, cyc_d;
  logic       store_q, store_d;
  logic [1:0] dimen_q, dimen_d;
  logic [3:0] addr_q, addr_d;
  logic [1:0] pe_sel_q, pe_sel_d;
  logic [1:0] pe_sub_q, pe_sub_d;

  // PE load delay line: stage 0 is written from the current state, and the
  // last stage drives PE_LD / PE_LD_IDX.
  logic [RD_LAT-1:0]      ld_v_q, ld_v_d;
  logic [RD_LAT-1:0][3:0] ld_idx_q, ld_idx_d;

  logic accept;
  logic abort_now;
  logic in_load;

  assign accept    = CMD_VALID && (state_q == S_IDLE);
  assign abort_now = (state_d == S_ABORT);
  assign in_load   = (state_q == S_LOAD);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // cyc_q does double duty. In LOAD/STORE it is the timeout counter, and its low
  // nibble is also the word index k, because it clears on LOAD entry and steps
  // once per LOAD cycle. A full 16-word load finishes before the earliest
  // possible timeout. In DRAIN it counts the read-latency cycles.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    store_d  = store_q;
    dimen_d  = dimen_q;
    addr_d   = addr_q;
    pe_sel_d = pe_sel_q;
    pe_sub_d = pe_sub_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          store_d  = CMD_STORE;
          dimen_d  = CMD_DIMEN;
          addr_d   = CMD_BASE;
          pe_sel_d = CMD_PE_SEL;
          pe_sub_d = CMD_PE_SUB;
          state_d  = S_CLR;
        end
      end

      S_CLR: begin
        cyc_d   = 8'd0;
        state_d = store_q ? S_STORE : S_LOAD;
      end

      S_LOAD: begin
        // The exit condition takes priority over the timeout in the same cycle.
        if (FETCH_DONE) begin
          cyc_d   = 8'd0;
          state_d = S_DRAIN;
        end else if (cyc_q == TMO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end

      S_STORE: begin
        if (STORE_DONE) begin
          state_d = S_DONE;
        end else if (cyc_q == TMO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end

      S_DRAIN: begin
        // Wait for the read data of the last addressed word to arrive.
        if (cyc_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PE load delay line
  // ---------------------------------------------------------------------------
  // When an abort is taken, the whole line is flushed so that no stale words
  // reach the PEs.
  assign ld_v_d[0]   = abort_now ? 1'b0 : in_load;
  assign ld_idx_d[0] = (abort_now || !in_load) ? 4'd0 : cyc_q[3:0];

  genvar gi;
  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_ld_stage
      assign ld_v_d[gi]   = abort_now ? 1'b0 : ld_v_q[gi-1];
      assign ld_idx_d[gi] = abort_now ? 4'd0 : ld_idx_q[gi-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= S_IDLE;
      cyc_q    <= 8'd0;
      store_q  <= 1'b0;
      dimen_q  <= 2'd0;
      addr_q   <= 4'd0;
      pe_sel_q <= 2'd0;
      pe_sub_q <= 2'd0;
      ld_v_q   <= '0;
      ld_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      store_q  <= store_d;
      dimen_q  <= dimen_d;
      addr_q   <= addr_d;
      pe_sel_q <= pe_sel_d;
      pe_sub_q <= pe_sub_d;
      ld_v_q   <= ld_v_d;
      ld_idx_q <= ld_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign CMD_READY    = (state_q == S_IDLE);
  assign BUSY         = (state_q != S_IDLE);
  assign DONE         = (state_q == S_DONE);
  assign ERR          = (state_q == S_ABORT);
  assign ADDR_RST     = (state_q == S_CLR) || (state_q == S_ABORT);
  // The word counter parks at its terminal value: it stops advancing as soon as
  // the done flag for the current transfer type is seen.
  assign ADDR_START   = (in_load && !FETCH_DONE) ||
                        ((state_q == S_STORE) && !STORE_DONE);
  assign WRADDR_START = (state_q == S_STORE);

  assign DIMEN        = dimen_q;
  assign ADDRESS      = addr_q;
  assign PE_SEL       = pe_sel_q;
  assign PE_SEL_4     = pe_sub_q[1];
  assign PE_SEL_2x2   = pe_sub_q[0];

  assign PE_LD        = ld_v_q[RD_LAT-1];
  assign PE_LD_IDX    = ld_idx_q[RD_LAT-1];

endmodule
